// File: rtl/serial_adder.sv
// Bit-serial unsigned WIDTH-bit adder: one full-adder slice evaluated per clock, LSB first,
// with a registered carry and a start/busy/done handshake around parallel operands/result.

module half_adder (
   input  logic a_i,
   input  logic b_i,
   output logic sum_o,
   output logic carry_o
);
   assign sum_o   = a_i ^ b_i;
   assign carry_o = a_i & b_i;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
   logic [WIDTH-1:0] res_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, busy_q, done_q;
   logic             carry_d;
   logic             prop_s, gen_s, sbit_s, cprop_s;

   // Full-adder slice on the current LSBs and the carry carried over from the previous bit.
   half_adder u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]),  .sum_o(prop_s), .carry_o(gen_s));
   half_adder u_ha1 (.a_i(prop_s), .b_i(carry_q), .sum_o(sbit_s), .carry_o(cprop_s));

   assign carry_d = gen_s | cprop_s;
   assign res_d   = {sbit_s, res_q[WIDTH-1:1]};

   // Handshake FSM, operand/result shifters, carry flop, bit counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         res_q   <= {WIDTH{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  res_q   <= {WIDTH{1'b0}};
                  carry_q <= 1'b0;
                  cnt_q   <= {CW{1'b0}};
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q     <= {1'b0, a_q[WIDTH-1:1]};
               b_q     <= {1'b0, b_q[WIDTH-1:1]};
               res_q   <= res_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_q + CW'(1);
               // Counter is sized so WIDTH-1 is reachable without wrapping.
               if (cnt_q == CW'(WIDTH - 1)) begin
                  sum_q   <= res_d;
                  cout_q  <= carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= RUN;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule
